// File: rtl/bus_arbiter_4.sv
// bus_arbiter_4 -- four-requester round-robin bus arbiter.
// Requesters: 0 PC, 1 MDR, 2 ALU, 3 MARMUX. Grant and SelectBit are
// registered; BusValid is derived from Grant. An owner keeps the bus until
// it drops its request; a release hands the bus to the next winner on the
// same edge so there are no dead cycles and no grant overlap.
// Optional feature: define BUS_ARB_TIMEOUT_EN to force a release once an
// owner has held the bus for MAX_HOLD cycles while another requester waits.
// Without it, ownership is unbounded and TimeoutErr is tied low.
// state_o exposes the FSM state (0 = IDLE, 1 = OWNED) for observation.
//
// Handshake: Req[i] is a level request held high for the whole transfer.
// Grant[i] is the acknowledgement; requester i owns the bus exactly while
// Grant[i] is high, and the transfer ends on the edge that samples Req[i]=0.

module bus_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] Req,
    output logic [3:0] Grant,
    output logic [1:0] SelectBit,
    output logic       BusValid,
    output logic       TimeoutErr,
    output logic       state_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] others;
    logic [1:0] nxt_ptr;
    logic [1:0] win;

    // First requester at or after ptr, wrapping modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign others  = Req & ~grant_q;
    assign nxt_ptr = sel_q + 2'd1;

`ifdef BUS_ARB_TIMEOUT_EN
    logic terr_q, terr_d;
`endif

    // Next-state logic: arbitration, release, hold counter and forced release.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        win     = 2'd0;
`ifdef BUS_ARB_TIMEOUT_EN
        terr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                grant_d = 4'b0000;
                if (|Req) begin
                    win     = pick(Req, ptr_q);
                    state_d = OWNED;
                    grant_d = 4'b0001 << win;
                    sel_d   = win;
                    cnt_d   = 4'd0;
                end
            end
            OWNED: begin
                if (!Req[sel_q]) begin
                    // Owner finished: rotate past it, hand over or go idle.
                    ptr_d = nxt_ptr;
                    cnt_d = 4'd0;
                    if (|others) begin
                        win     = pick(others, nxt_ptr);
                        grant_d = 4'b0001 << win;
                        sel_d   = win;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                    end
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_q == HOLD_LAST && (|others)) begin
                    // Owner overstayed while someone waits: force hand-over.
                    ptr_d   = nxt_ptr;
                    cnt_d   = 4'd0;
                    win     = pick(others, nxt_ptr);
                    grant_d = 4'b0001 << win;
                    sel_d   = win;
                    terr_d  = 1'b1;
                end
`endif
                else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // State registers; reset clears everything asynchronously.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // One-cycle pulse marking a forced release.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            terr_q <= 1'b0;
        end else begin
            terr_q <= terr_d;
        end
    end
    assign TimeoutErr = terr_q;
`else
    assign TimeoutErr = 1'b0;
`endif

    assign Grant     = grant_q;
    assign SelectBit = sel_q;
    assign BusValid  = |grant_q;
    assign state_o   = state_q;

endmodule
